// File: rtl/axis_argmax.sv
// axis_argmax: streams NUM_CLASSES signed scores per image and emits the index of the largest one
module axis_argmax #(
  parameter int WIDTH       = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] max_score,
  output logic             done
);
  typedef enum logic {COLLECT, OUTPUT} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx, best_idx, best_idx_nx;
  logic [WIDTH-1:0] best, best_nx;
  logic s_fire, last, take;
  assign s_ready   = rst & (state == COLLECT);
  assign m_valid   = state == OUTPUT;
  assign m_data    = WIDTH'(best_idx);
  assign max_score = best;
  assign done      = m_valid & m_ready;
  // The first beat loads unconditionally so the previous image never leaks in; ties keep the lower index
  always_comb begin
    s_fire      = s_valid & s_ready;
    last        = cnt == IDX_W'(NUM_CLASSES - 1);
    take        = s_fire & ((cnt == '0) | ($signed(s_data) > $signed(best)));
    best_nx     = take ? s_data : best;
    best_idx_nx = take ? cnt : best_idx;
    cnt_nx      = s_fire ? (last ? '0 : cnt + IDX_W'(1)) : cnt;
    state_nx    = state == COLLECT ? ((s_fire & last) ? OUTPUT : COLLECT)
                                   : (m_ready ? COLLECT : OUTPUT);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      best     <= best_nx;
      best_idx <= best_idx_nx;
    end
  end
endmodule

// File: tb/tb_axis_argmax.sv
// tb_axis_argmax: directed and randomized-gap checks of axis_argmax against hand-computed argmax results
module tb_axis_argmax;
  typedef logic [31:0] img_t [10];
  logic        clk = 0, rst = 0, s_valid = 0, m_ready = 1;
  logic [31:0] s_data = '0;
  logic        s_ready, m_valid, done;
  logic [31:0] m_data, max_score;
  int n_assert = 0, n_fail = 0;

  axis_argmax #(.WIDTH(32), .NUM_CLASSES(10), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .max_score(max_score), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int t = 0;
    s_valid = 0;
    repeat (gap) step();
    s_valid = 1;
    s_data  = d;
    while (!s_ready && t < 50) begin
      step();
      t++;
    end
    if (t == 50) check("s_ready_timeout", {31'b0, s_ready}, 32'd1);
    step();
    s_valid = 0;
  endtask

  task automatic run_image(input string tag, input img_t sc, input int max_gap,
                           input logic [31:0] exp_idx, input logic [31:0] exp_max);
    for (int i = 0; i < 10; i++) begin
      send(sc[i], max_gap == 0 ? 0 : $urandom_range(0, max_gap));
      if (i < 9) check({tag, "_early_valid"}, {31'b0, m_valid}, 32'd0);
    end
    check({tag, "_m_valid"}, {31'b0, m_valid}, 32'd1);
    check({tag, "_m_data"}, m_data, exp_idx);
    check({tag, "_max_score"}, max_score, exp_max);
    if (m_ready) begin
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      step();
      check({tag, "_m_valid_drop"}, {31'b0, m_valid}, 32'd0);
      check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    img_t img;
    logic [31:0] bm;
    logic [31:0] bi;
    logic        stable;
    // reset state
    #12;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_max_score", max_score, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    @(negedge clk);
    rst = 1;
    step();
    check("post_rst_s_ready", {31'b0, s_ready}, 32'd1);

    // 1: basic argmax
    run_image("t1", '{5, 3, 9, 1, 0, 2, 8, 7, 4, 6}, 0, 32'd2, 32'd9);
    // 2: ties resolve to lowest index
    img = '{default: -32'sd7};
    run_image("t2", img, 0, 32'd0, -32'sd7);
    // 3: negatives with the most-negative value
    run_image("t3", '{-32'sd100, -32'sd50, -32'sd30, 32'h80000000, -32'sd20,
                      -32'sd10, -32'sd5, -32'sd3, -32'sd2, -32'sd1}, 0, 32'd9, 32'hFFFFFFFF);
    // 3b: an unsigned compare would pick -1 at index 5
    run_image("t3b", '{32'h80000000, -32'sd3, 32'd1, -32'sd8, 32'h80000000,
                       -32'sd1, 32'd0, -32'sd2, 32'd0, -32'sd5}, 0, 32'd2, 32'd1);
    // 3c: all most-negative, first beat must load over the stale best
    img = '{default: 32'h80000000};
    run_image("t3c", img, 0, 32'd0, 32'h80000000);

    // 4: backpressure
    m_ready = 0;
    run_image("t4", '{5, 3, 9, 1, 0, 2, 8, 7, 4, 6}, 0, 32'd2, 32'd9);
    stable  = 1;
    s_valid = 1;
    s_data  = 32'd99;
    repeat (20) begin
      step();
      stable &= m_valid & ~s_ready & ~done & (m_data == 32'd2) & (max_score == 32'd9);
    end
    s_valid = 0;
    check("t4_stable", {31'b0, stable}, 32'd1);
    m_ready = 1;
    #1;
    check("t4_done", {31'b0, done}, 32'd1);
    step();
    check("t4_s_ready", {31'b0, s_ready}, 32'd1);
    check("t4_m_valid_drop", {31'b0, m_valid}, 32'd0);
    run_image("t4_next", '{1, 2, 3, 4, 5, 6, 7, 8, 10, 9}, 0, 32'd8, 32'd10);

    // 5: random gaps against a reference argmax
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 10; i++)
        img[i] = $urandom_range(0, 3) == 0 ? 32'(-$urandom_range(0, 4)) :
                 $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      bm = img[0];
      bi = 0;
      for (int i = 1; i < 10; i++)
        if ($signed(img[i]) > $signed(bm)) begin
          bm = img[i];
          bi = 32'(i);
        end
      run_image("t5", img, 2, bi, bm);
    end

    // 6: reset mid-image discards stale beats
    for (int i = 0; i < 4; i++) send(32'd100, 0);
    rst = 0;
    #1;
    check("t6_s_ready_in_rst", {31'b0, s_ready}, 32'd0);
    check("t6_m_valid_in_rst", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    rst = 1;
    step();
    img = '{default: 32'd0};
    img[9] = 32'd42;
    run_image("t6", img, 0, 32'd9, 32'd42);

    // 6b: reset while holding a result drops m_valid immediately
    m_ready = 0;
    run_image("t6b", '{5, 3, 9, 1, 0, 2, 8, 7, 4, 6}, 0, 32'd2, 32'd9);
    rst = 0;
    #1;
    check("t6b_m_valid_drop", {31'b0, m_valid}, 32'd0);
    check("t6b_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1;
    m_ready = 1;
    step();
    run_image("t6b_next", '{0, 0, 7, 0, 0, 0, 0, 7, 0, 0}, 0, 32'd2, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
